// File: rtl/lib_switchblock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lib_switchblock_pkg
// Purpose  : Shared definitions for the DEM switching tree: code width, the
//            per-sample mode encoding, the node split result and helpers for
//            tree sizing and node arithmetic.
// Contents : INPUT_WIDTH      width of input, node and leaf codes
//            sb_mode_e        SB_SHAPED (0) / SB_STATIC (1)
//            sb_split_t       {out1, out2} pair produced by one node
//            sb_num_leaves()  2**layers
//            sb_num_nodes()   2**layers - 1
//            sb_split()       split one code into two halves
// Revision : 1.0 - initial parametrised release
// ============================================================================
package lib_switchblock_pkg;

  localparam int INPUT_WIDTH = 4;

  typedef enum logic {
    SB_SHAPED = 1'b0,
    SB_STATIC = 1'b1
  } sb_mode_e;

  typedef struct packed {
    logic [INPUT_WIDTH-1:0] out1;
    logic [INPUT_WIDTH-1:0] out2;
  } sb_split_t;

  function automatic int sb_num_leaves(input int layers);
    return 1 << layers;
  endfunction

  function automatic int sb_num_nodes(input int layers);
    return (1 << layers) - 1;
  endfunction

  // Splits x into two codes that sum to x. For odd x the half that receives
  // the extra unit is chosen by s_pos: 1 gives out1 = ceil, out2 = floor.
  // ceil(x/2) is formed as floor(x/2) + lsb, which tops out at 2**(W-1) and
  // therefore never wraps, even for x = all ones.
  function automatic sb_split_t sb_split(input logic [INPUT_WIDTH-1:0] x,
                                         input logic                   s_pos);
    logic [INPUT_WIDTH-1:0] lo;
    logic [INPUT_WIDTH-1:0] hi;
    sb_split_t              r;
    lo     = {1'b0, x[INPUT_WIDTH-1:1]};
    hi     = lo + {{(INPUT_WIDTH-1){1'b0}}, x[0]};
    r.out1 = s_pos ? hi : lo;
    r.out2 = s_pos ? lo : hi;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dem_switch_node.sv
`default_nettype none
// ============================================================================
// Module   : dem_switch_node
// Purpose  : One switching node of the DEM tree. Splits its input code into
//            two halves, keeps a first-order shaping sign, and registers its
//            outputs together with the sample's valid and mode.
// Ports    : clk_i    in   clock, rising edge
//            reset_i  in   synchronous active-high reset
//            x_i      in   INPUT_WIDTH code from parent (or tree input)
//            valid_i  in   qualifies x_i / mode_i
//            mode_i   in   mode the sample entered the tree with
//            out1_o   out  registered first half (feeds child 2i+1 / leaf 2k)
//            out2_o   out  registered second half (feeds child 2i+2 / leaf 2k+1)
//            valid_o  out  registered valid
//            mode_o   out  registered mode, forwarded to children
//            sel_o    out  registered sign state, 1 = +1, 0 = -1
// Revision : 1.0 - initial parametrised release
// ============================================================================
module dem_switch_node
  import lib_switchblock_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [INPUT_WIDTH-1:0] x_i,
  input  logic                   valid_i,
  input  sb_mode_e               mode_i,
  output logic [INPUT_WIDTH-1:0] out1_o,
  output logic [INPUT_WIDTH-1:0] out2_o,
  output logic                   valid_o,
  output sb_mode_e               mode_o,
  output logic                   sel_o
);

  logic [INPUT_WIDTH-1:0] out1_q, out1_d;
  logic [INPUT_WIDTH-1:0] out2_q, out2_d;
  logic                   valid_q, valid_d;
  sb_mode_e               mode_q, mode_d;
  logic                   sel_q, sel_d;

  logic                   s_pos;
  sb_split_t              split;

  always_comb begin
    // STATIC samples always round out1 up and leave the sign untouched.
    s_pos   = (mode_i == SB_STATIC) || sel_q;
    split   = sb_split(x_i, s_pos);

    out1_d  = out1_q;
    out2_d  = out2_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    valid_d = valid_i;

    if (valid_i) begin
      out1_d = split.out1;
      out2_d = split.out2;
      mode_d = mode_i;
      // Alternating the sign on every odd code spreads the extra unit
      // evenly over both subtrees (first-order shaping).
      if ((mode_i == SB_SHAPED) && x_i[0]) begin
        sel_d = ~sel_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out1_q  <= '0;
      out2_q  <= '0;
      valid_q <= 1'b0;
      mode_q  <= SB_SHAPED;
      sel_q   <= 1'b1;
    end else begin
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
    end
  end

  assign out1_o  = out1_q;
  assign out2_o  = out2_q;
  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign sel_o   = sel_q;

endmodule
`default_nettype wire

// File: rtl/dem_switch_tree.sv
`default_nettype none
// ============================================================================
// Module   : dem_switch_tree
// Purpose  : Parametrised, pipelined binary switching tree for the DEM DAC.
//            An input code is split over LAYERS layers of switching nodes
//            into 2**LAYERS leaf codes; one register stage per layer.
// Ports    : clk_i        in   clock, rising edge
//            reset_i      in   synchronous active-high reset
//            x_in_i       in   INPUT_WIDTH unsigned input code
//            in_valid_i   in   qualifies x_in_i
//            mode_i       in   0 = SHAPED, 1 = STATIC, travels with sample
//            x_leaf_o     out  leaf j at [j*INPUT_WIDTH +: INPUT_WIDTH]
//            out_valid_o  out  leaf codes updated this cycle
//            node_sel_o   out  per-node sign state, heap order (bit 0 = root)
// Revision : 1.0 - initial parametrised release
// ============================================================================
module dem_switch_tree
  import lib_switchblock_pkg::*;
#(
  parameter  int LAYERS     = 3,
  localparam int NUM_LEAVES = sb_num_leaves(LAYERS),
  localparam int NUM_NODES  = sb_num_nodes(LAYERS)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [INPUT_WIDTH-1:0]            x_in_i,
  input  logic                              in_valid_i,
  input  logic                              mode_i,
  output logic [NUM_LEAVES*INPUT_WIDTH-1:0] x_leaf_o,
  output logic                              out_valid_o,
  output logic [NUM_NODES-1:0]              node_sel_o
);

  // First heap index of the last layer; its nodes drive the leaves.
  localparam int LAST_BASE = NUM_NODES / 2;

  // Per-node signals, indexed by heap position.
  logic [INPUT_WIDTH-1:0] node_x    [NUM_NODES];
  logic                   node_vin  [NUM_NODES];
  sb_mode_e               node_min  [NUM_NODES];
  logic [INPUT_WIDTH-1:0] node_out1 [NUM_NODES];
  logic [INPUT_WIDTH-1:0] node_out2 [NUM_NODES];
  logic                   node_vout [NUM_NODES];
  sb_mode_e               node_mout [NUM_NODES];
  logic [NUM_NODES-1:0]   node_sel;

  for (genvar i = 0; i < NUM_NODES; i++) begin : g_node
    if (i == 0) begin : g_root
      assign node_x[i]   = x_in_i;
      assign node_vin[i] = in_valid_i;
      assign node_min[i] = sb_mode_e'(mode_i);
    end else begin : g_child
      localparam int PARENT = (i - 1) / 2;
      // Odd heap indices are left children (parent's out1).
      if ((i % 2) == 1) begin : g_left
        assign node_x[i] = node_out1[PARENT];
      end else begin : g_right
        assign node_x[i] = node_out2[PARENT];
      end
      assign node_vin[i] = node_vout[PARENT];
      assign node_min[i] = node_mout[PARENT];
    end

    dem_switch_node u_node (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .x_i     (node_x[i]),
      .valid_i (node_vin[i]),
      .mode_i  (node_min[i]),
      .out1_o  (node_out1[i]),
      .out2_o  (node_out2[i]),
      .valid_o (node_vout[i]),
      .mode_o  (node_mout[i]),
      .sel_o   (node_sel[i])
    );
  end

  // Last-layer node k owns leaves 2k and 2k+1, so the leaf bus is simply the
  // last layer's output registers laid out left to right.
  for (genvar k = 0; k < NUM_LEAVES / 2; k++) begin : g_leaf
    assign x_leaf_o[(2*k)*INPUT_WIDTH   +: INPUT_WIDTH] = node_out1[LAST_BASE + k];
    assign x_leaf_o[(2*k+1)*INPUT_WIDTH +: INPUT_WIDTH] = node_out2[LAST_BASE + k];
  end

  // All last-layer valids carry the same sample, any one of them will do.
  assign out_valid_o = node_vout[LAST_BASE];
  assign node_sel_o  = node_sel;

endmodule
`default_nettype wire

// File: tb/tb_dem_switch_tree.sv
`default_nettype none
// ============================================================================
// Module   : tb_dem_switch_tree
// Purpose  : Self-checking bench for dem_switch_tree (LAYERS = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dem_switch_tree;
  import lib_switchblock_pkg::*;

  localparam int LAYERS = 3;
  localparam int NL     = 8;
  localparam int NN     = 7;
  localparam int W      = INPUT_WIDTH;
  localparam int LW     = NL * W;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          mode_i = 1'b0;
  logic [W-1:0]  x_in_i = '0;
  logic [LW-1:0] x_leaf_o;
  logic          out_valid_o;
  logic [NN-1:0] node_sel_o;

  always #5 clk = ~clk;

  dem_switch_tree #(.LAYERS(LAYERS)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .x_in_i      (x_in_i),
    .in_valid_i  (in_valid_i),
    .mode_i      (mode_i),
    .x_leaf_o    (x_leaf_o),
    .out_valid_o (out_valid_o),
    .node_sel_o  (node_sel_o)
  );

  typedef struct {
    logic [LW-1:0] leaves;
    int            due;
    int            x;
  } exp_t;

  typedef struct {
    int            x;
    int            mode;
    int            leaves [NL];
    logic [NN-1:0] sel;
  } vec_t;

  exp_t          expq[$];
  logic [LW-1:0] got[$];
  logic [LW-1:0] last_leaves = '0;
  int            sel_m [NN];
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  bit            chk_en = 1'b0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endfunction

  function automatic logic [LW-1:0] pack8(input int l [NL]);
    logic [LW-1:0] v;
    v = '0;
    for (int j = 0; j < NL; j++) v[j*W +: W] = W'(l[j]);
    return v;
  endfunction

  function automatic int leaf_sum(input logic [LW-1:0] v);
    int s;
    s = 0;
    for (int j = 0; j < NL; j++) s += int'(v[j*W +: W]);
    return s;
  endfunction

  function automatic logic [NN-1:0] sel_packed();
    logic [NN-1:0] s;
    for (int i = 0; i < NN; i++) s[i] = (sel_m[i] != 0);
    return s;
  endfunction

  function automatic void model_reset();
    expq.delete();
    for (int i = 0; i < NN; i++) sel_m[i] = 1;
    last_leaves = '0;
  endfunction

  // Whole-sample reference: walk the heap top-down with plain integers. Samples
  // visit every node in entry order, so updating sign state at entry time gives
  // the same per-sample result as the pipelined hardware.
  function automatic void model_push(input int x, input int m);
    int   v [NN+NL];
    int   s;
    int   l [NL];
    exp_t e;
    v[0] = x;
    for (int i = 0; i < NN; i++) begin
      if (v[i] % 2 == 0) begin
        v[2*i+1] = v[i] / 2;
        v[2*i+2] = v[i] / 2;
      end else begin
        s = (m == 1 || sel_m[i] == 1) ? 1 : -1;
        v[2*i+1] = (v[i] + s) / 2;
        v[2*i+2] = (v[i] - s) / 2;
        if (m == 0) sel_m[i] = 1 - sel_m[i];
      end
    end
    for (int j = 0; j < NL; j++) l[j] = v[NN+j];
    e.leaves = pack8(l);
    e.due    = cyc + LAYERS;
    e.x      = x;
    expq.push_back(e);
  endfunction

  task automatic check_outputs();
    exp_t e;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      check("out_valid_due", 64'(out_valid_o), 64'd1);
      check("leaves", 64'(x_leaf_o), 64'(e.leaves));
      check("leaf_sum", 64'(leaf_sum(x_leaf_o)), 64'(e.x));
      got.push_back(x_leaf_o);
      last_leaves = e.leaves;
    end else begin
      check("out_valid_idle", 64'(out_valid_o), 64'd0);
      check("leaves_hold", 64'(x_leaf_o), 64'(last_leaves));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (chk_en) check_outputs();
  endtask

  task automatic drive(input bit v, input int x, input int m);
    in_valid_i = v;
    x_in_i     = W'(x);
    mode_i     = m[0];
    if (v && !reset_i) model_push(x, m);
  endtask

  task automatic do_reset(input int n);
    reset_i    = 1'b1;
    in_valid_i = 1'b0;
    model_reset();
    repeat (n) tick();
    reset_i = 1'b0;
  endtask

  task automatic drain(input int n);
    drive(1'b0, 0, 0);
    repeat (n) tick();
  endtask

  vec_t tbl [4];
  int   l5a [NL] = '{1, 1, 1, 0, 1, 0, 1, 0};
  int   l5b [NL] = '{1, 0, 0, 1, 1, 1, 0, 1};
  int   l3s [NL] = '{1, 0, 1, 0, 1, 0, 0, 0};

  initial begin
    tbl[0] = '{x: 8,  mode: 0, leaves: '{1, 1, 1, 1, 1, 1, 1, 1}, sel: 7'b1111111};
    tbl[1] = '{x: 3,  mode: 1, leaves: '{1, 0, 1, 0, 1, 0, 0, 0}, sel: 7'b1111111};
    tbl[2] = '{x: 15, mode: 0, leaves: '{2, 2, 2, 2, 2, 2, 2, 1}, sel: 7'b0111010};
    tbl[3] = '{x: 5,  mode: 0, leaves: '{1, 1, 1, 0, 1, 0, 1, 0}, sel: 7'b0001100};

    // Reset state
    do_reset(2);
    check("reset_leaves", 64'(x_leaf_o), 64'd0);
    check("reset_valid", 64'(out_valid_o), 64'd0);
    check("reset_sel", 64'(node_sel_o), 64'h7F);
    chk_en = 1'b1;

    // Single-sample vectors from a fresh reset
    for (int t = 0; t < 4; t++) begin
      do_reset(2);
      got.delete();
      drive(1'b1, tbl[t].x, tbl[t].mode);
      tick();
      drain(LAYERS + 2);
      check("vec_count", 64'(got.size()), 64'd1);
      if (got.size() >= 1) check("vec_leaves", 64'(got[0]), 64'(pack8(tbl[t].leaves)));
      check("vec_sel", 64'(node_sel_o), 64'(tbl[t].sel));
      check("vec_sel_model", 64'(node_sel_o), 64'(sel_packed()));
    end

    // Two consecutive SHAPED 5s
    do_reset(2);
    got.delete();
    drive(1'b1, 5, 0); tick();
    drive(1'b1, 5, 0); tick();
    drain(LAYERS + 2);
    check("b2b_count", 64'(got.size()), 64'd2);
    if (got.size() >= 2) begin
      check("b2b_first", 64'(got[0]), 64'(pack8(l5a)));
      check("b2b_second", 64'(got[1]), 64'(pack8(l5b)));
    end

    // Four consecutive STATIC 3s
    do_reset(2);
    got.delete();
    repeat (4) begin
      drive(1'b1, 3, 1); tick();
    end
    drain(LAYERS + 2);
    check("static_count", 64'(got.size()), 64'd4);
    foreach (got[i]) check("static_leaves", 64'(got[i]), 64'(pack8(l3s)));
    check("static_sel", 64'(node_sel_o), 64'h7F);

    // Valid pattern 1,0,1 with a gap
    do_reset(2);
    got.delete();
    drive(1'b1, 5, 0); tick();
    drive(1'b0, 9, 0); tick();
    drive(1'b1, 5, 0); tick();
    drain(LAYERS + 2);
    check("gap_count", 64'(got.size()), 64'd2);
    if (got.size() >= 2) check("gap_second", 64'(got[1]), 64'(pack8(l5b)));

    // Reset with two samples in flight
    do_reset(2);
    got.delete();
    drive(1'b1, 9, 0); tick();
    drive(1'b1, 6, 0); tick();
    drive(1'b0, 0, 0);
    reset_i = 1'b1;
    model_reset();
    tick();
    reset_i = 1'b0;
    repeat (LAYERS + 3) tick();
    check("flush_count", 64'(got.size()), 64'd0);
    check("flush_sel", 64'(node_sel_o), 64'h7F);
    check("flush_leaves", 64'(x_leaf_o), 64'd0);

    // Randomised traffic with occasional resets
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        drive(1'b0, 0, 0);
        reset_i = 1'b1;
        model_reset();
      end else begin
        reset_i = 1'b0;
        drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1)));
      end
      tick();
      if (i % 50 == 49) begin
        reset_i = 1'b0;
        drain(LAYERS + 1);
        check("rand_sel", 64'(node_sel_o), 64'(sel_packed()));
      end
    end
    reset_i = 1'b0;
    drain(LAYERS + 2);
    check("final_sel", 64'(node_sel_o), 64'(sel_packed()));
    check("queue_empty", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
